// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg: sequencer state encoding and width helpers for counters sized from instance parameters
package cnn_seq_pkg;
  typedef enum logic [1:0] {PRST, LOAD, DRAIN, REPORT} seq_state_t;
  function automatic int pix_cnt_w(input int image_width);
    return $clog2(image_width * image_width + 1);
  endfunction
  function automatic int timer_w(input int reset_cycles, input int timeout_cycles);
    return $clog2(reset_cycles > timeout_cycles ? reset_cycles : timeout_cycles);
  endfunction
endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// cnn_frame_sequencer_if: pixel source, pipeline and result consumer signals; slave = sequencer view, master = environment view
interface cnn_frame_sequencer_if #(
  parameter int BitSize = 32,
  parameter int NumOut  = 2
);
  logic                      pix_valid;
  logic [BitSize-1:0]        pix_data;
  logic                      pix_ready;
  logic                      pipe_reset;
  logic                      pipe_in_valid;
  logic [BitSize-1:0]        pipe_in_data;
  logic                      pipe_out_ready;
  logic [NumOut*BitSize-1:0] pipe_out_data;
  logic                      pipe_out_valid;
  logic                      pipe_out_done;
  logic                      res_valid;
  logic [NumOut*BitSize-1:0] res_data;
  logic                      res_timeout;
  logic                      res_ready;
  logic [15:0]               frame_count;
  modport slave (
    input  pix_valid, pix_data, pipe_out_ready, pipe_out_data, pipe_out_valid, pipe_out_done, res_ready,
    output pix_ready, pipe_reset, pipe_in_valid, pipe_in_data, res_valid, res_data, res_timeout, frame_count
  );
  modport master (
    output pix_valid, pix_data, pipe_out_ready, pipe_out_data, pipe_out_valid, pipe_out_done, res_ready,
    input  pix_ready, pipe_reset, pipe_in_valid, pipe_in_data, res_valid, res_data, res_timeout, frame_count
  );
endinterface

// File: rtl/cycle_timer.sv
// cycle_timer: loadable down-counter saturating at zero; clk, load/value (load has priority), en (count), zero (count is 0)
module cycle_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk) begin
    if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: gates one frame into the pipeline, captures the result, resets the pipeline between frames; clk, res_n (sync active-high reset), bus (slave)
module cnn_frame_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int BitSize       = 32,
  parameter int ImageWidth    = 8,
  parameter int NumOut        = 2,
  parameter int ResetCycles   = 2,
  parameter int TimeoutCycles = 1024
) (
  input logic clk,
  input logic res_n,
  cnn_frame_sequencer_if.slave bus
);
  localparam int PW = pix_cnt_w(ImageWidth);
  localparam int TW = timer_w(ResetCycles, TimeoutCycles);
  localparam logic [PW-1:0] LastPix = PW'(ImageWidth * ImageWidth - 1);
  localparam logic [TW-1:0] RstLd = TW'(ResetCycles - 1);
  localparam logic [TW-1:0] ToLd = TW'(TimeoutCycles - 1);
  seq_state_t                state;
  logic [PW-1:0]             pix_cnt;
  logic [NumOut*BitSize-1:0] cap;
  logic [15:0]               frame_cnt;
  logic                      pipe_reset, res_valid, res_timeout;
  logic                      pix_ready, in_hs, last_pix, res_hs, t_load, t_zero;
  logic [TW-1:0]             t_value;
  assign pix_ready = !res_n && state == LOAD && bus.pipe_out_ready;
  assign in_hs     = bus.pix_valid && pix_ready;
  assign last_pix  = pix_cnt == LastPix;
  assign res_hs    = state == REPORT && bus.res_ready;
  // one timer serves both phases: reset hold is loaded on entry to PRST, watchdog on entry to DRAIN
  assign t_load  = res_n || res_hs || (in_hs && last_pix);
  assign t_value = in_hs ? ToLd : RstLd;
  cycle_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .load  (t_load),
    .value (t_value),
    .en    (1'b1),
    .zero  (t_zero)
  );
  always_ff @(posedge clk) begin
    if (res_n) begin
      state       <= PRST;
      pix_cnt     <= '0;
      cap         <= '0;
      frame_cnt   <= '0;
      pipe_reset  <= 1'b1;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        PRST: begin
          pix_cnt     <= '0;
          cap         <= '0;
          res_timeout <= 1'b0;
          if (t_zero) begin
            state      <= LOAD;
            pipe_reset <= 1'b0;
          end
        end
        LOAD: begin
          if (in_hs) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (last_pix) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.pipe_out_valid) cap <= bus.pipe_out_data;
          // done takes precedence over a coincident watchdog expiry
          if (bus.pipe_out_done || t_zero) begin
            state       <= REPORT;
            res_valid   <= 1'b1;
            res_timeout <= !bus.pipe_out_done;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            state       <= PRST;
            pipe_reset  <= 1'b1;
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            frame_cnt   <= frame_cnt + 1'b1;
          end
        end
      endcase
    end
  end
  assign bus.pix_ready     = pix_ready;
  assign bus.pipe_in_valid = in_hs;
  assign bus.pipe_in_data  = bus.pix_data;
  assign bus.pipe_reset    = pipe_reset;
  assign bus.res_valid     = res_valid;
  assign bus.res_data      = cap;
  assign bus.res_timeout   = res_timeout;
  assign bus.frame_count   = frame_cnt;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: directed self-checking bench for cnn_frame_sequencer
module tb_cnn_frame_sequencer;
  localparam int BW = 32, IW = 4, NO = 2, RC = 2, TO = 8, NPIX = IW * IW;
  logic clk = 1'b0;
  logic res_n = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [BW-1:0] rx_q[$];
  cnn_frame_sequencer_if #(.BitSize(BW), .NumOut(NO)) bus ();
  cnn_frame_sequencer #(
    .BitSize(BW), .ImageWidth(IW), .NumOut(NO), .ResetCycles(RC), .TimeoutCycles(TO)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    if (bus.pipe_in_valid) rx_q.push_back(bus.pipe_in_data);
  end
  function automatic logic [63:0] pair(input int hi, input int lo);
    return {BW'(hi), BW'(lo)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_prst(input string tag);
    for (int i = 0; i < RC; i++) begin
      chk({tag, "_pipe_reset_hi"}, bus.pipe_reset, 1);
      @(negedge clk);
    end
    chk({tag, "_pipe_reset_lo"}, bus.pipe_reset, 0);
    #1 chk({tag, "_load_ready"}, bus.pix_ready, 1);
  endtask
  task automatic send_frame(input int n, input int base, input bit toggle);
    int sent = 0;
    int guard = 0;
    rx_q.delete();
    while (sent < n && guard < 4 * n + 8) begin
      bus.pix_valid = 1'b1;
      bus.pix_data = BW'(base + sent);
      bus.pipe_out_ready = toggle ? ~bus.pipe_out_ready : 1'b1;
      #1;
      if (toggle) chk("pix_ready_mirror", bus.pix_ready, bus.pipe_out_ready);
      if (bus.pix_ready) sent++;
      @(negedge clk);
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.pipe_out_ready = 1'b1;
    chk("frame_accept", sent, n);
  endtask
  task automatic drain_done(input int delay, input logic [63:0] data);
    bus.pix_valid = 1'b1;
    bus.pix_data = 99;
    #1;
    chk("drain_no_ready", bus.pix_ready, 0);
    chk("drain_no_push", bus.pipe_in_valid, 0);
    for (int k = 1; k < delay; k++) begin
      bus.pipe_out_valid = k == 2;
      bus.pipe_out_data = pair(1, 1);
      @(negedge clk);
    end
    chk("res_before_done", bus.res_valid, 0);
    bus.pix_valid = 1'b0;
    bus.pipe_out_valid = 1'b1;
    bus.pipe_out_done = 1'b1;
    bus.pipe_out_data = data;
    @(negedge clk);
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done = 1'b0;
  endtask
  task automatic watch(input bit late_done);
    for (int k = 0; k < TO; k++) begin
      bus.pipe_out_valid = (k == 2) || (late_done && k == TO - 1);
      bus.pipe_out_done = late_done && k == TO - 1;
      bus.pipe_out_data = (k == 2) ? pair(3, 4) : pair(5, 6);
      if (k == TO - 1) chk("no_early_result", bus.res_valid, 0);
      @(negedge clk);
    end
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done = 1'b0;
  endtask
  task automatic check_rx(input int base);
    chk("pulse_count", rx_q.size(), NPIX);
    for (int i = 0; i < NPIX && i < rx_q.size(); i++) chk("pixel_order", rx_q[i], base + i);
  endtask
  task automatic finish_result(input int stall, input logic [63:0] exp, input bit to, input int cnt);
    chk("res_valid", bus.res_valid, 1);
    chk("res_data", bus.res_data, exp);
    chk("res_timeout", bus.res_timeout, to);
    repeat (stall) begin
      @(negedge clk);
      chk("res_hold_valid", bus.res_valid, 1);
      chk("res_hold_data", bus.res_data, exp);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_cleared", bus.res_valid, 0);
    chk("frame_count", bus.frame_count, cnt);
    expect_prst("post_result");
  endtask
  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.pipe_out_ready = 1'b1;
    bus.pipe_out_data = '0;
    bus.pipe_out_valid = 1'b0;
    bus.pipe_out_done = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_data = 32'hA5;
    #1;
    chk("rst_pipe_reset", bus.pipe_reset, 1);
    chk("rst_pix_ready", bus.pix_ready, 0);
    chk("rst_pipe_in_valid", bus.pipe_in_valid, 0);
    chk("rst_pipe_in_data", bus.pipe_in_data, 32'hA5);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_timeout", bus.res_timeout, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_frame_count", bus.frame_count, 0);
    bus.pix_valid = 1'b0;
    @(negedge clk);
    res_n = 1'b0;
    expect_prst("init");
    send_frame(9, 201, 1'b0);
    res_n = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data = 210;
    #1 chk("abort_no_ready", bus.pix_ready, 0);
    @(negedge clk);
    res_n = 1'b0;
    bus.pix_valid = 1'b0;
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_frame_count", bus.frame_count, 0);
    chk("abort_pixels", rx_q.size(), 9);
    expect_prst("abort");
    send_frame(NPIX, 1, 1'b0);
    drain_done(5, pair(7, 9));
    check_rx(1);
    finish_result(0, pair(7, 9), 1'b0, 1);
    send_frame(NPIX, 301, 1'b1);
    drain_done(3, pair(11, 12));
    check_rx(301);
    finish_result(0, pair(11, 12), 1'b0, 2);
    send_frame(NPIX, 401, 1'b0);
    watch(1'b0);
    check_rx(401);
    finish_result(10, pair(3, 4), 1'b1, 3);
    send_frame(NPIX, 501, 1'b0);
    watch(1'b1);
    check_rx(501);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    #1 chk("preload", bus.frame_count, 16'hFFFF);
    finish_result(0, pair(5, 6), 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: got expired expected finish");
    $fatal(1);
  end
endmodule
